// File: rtl/food_gen.sv
// food_gen: LFSR-driven food placement with occupancy RAM check and retry.
// Define FOOD_FALLBACK_SCAN_EN to add a linear scan once random tries run out.
module food_gen #(
  parameter int          GRID_W    = 40,
  parameter int          GRID_H    = 30,
  parameter int          X_W       = 6,
  parameter int          Y_W       = 5,
  parameter int          ADDR_W    = 11,
  parameter int          MAX_TRIES = 64,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic              clk,
  input  logic              RSTN,
  input  logic              gen_req,
  output logic              occ_rd_en,
  output logic [ADDR_W-1:0] occ_addr,
  input  logic              occ_data,
  output logic [X_W-1:0]    food_x,
  output logic [Y_W-1:0]    food_y,
  output logic              food_valid,
  output logic              busy,
  output logic              fail
);

  localparam logic [15:0] SEED_I =
    (SEED == 16'h0) ? 16'hACE1 : SEED;
  localparam logic [7:0] MT = 8'(MAX_TRIES);
  localparam logic [X_W:0] GW = (X_W+1)'(GRID_W);
  localparam logic [Y_W:0] GH = (Y_W+1)'(GRID_H);
  localparam logic [ADDR_W-1:0] GW_A = ADDR_W'(GRID_W);
`ifdef FOOD_FALLBACK_SCAN_EN
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(GRID_W * GRID_H - 1);
  localparam logic [X_W-1:0] X_LAST = X_W'(GRID_W - 1);
`endif

`ifdef FOOD_FALLBACK_SCAN_EN
  typedef enum logic [2:0] {
    IDLE, DRAW, READ, CHECK, DONE, FAIL, SCAN, SCAN_CHK
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, DRAW, READ, CHECK, DONE, FAIL
  } state_t;
`endif

  state_t state;
  logic [15:0] lfsr;
  logic [7:0] tries;
  logic [X_W-1:0] cand_x;
  logic [Y_W-1:0] cand_y;

  logic [X_W-1:0] draw_x;
  logic [Y_W-1:0] draw_y;
  logic in_range;
  logic [7:0] tries_n;
  logic [ADDR_W-1:0] draw_addr;

  always_comb begin
    draw_x    = lfsr[X_W-1:0];
    draw_y    = lfsr[8 +: Y_W];
    in_range  = ({1'b0, draw_x} < GW) &&
                ({1'b0, draw_y} < GH);
    tries_n   = tries + 8'd1;
    draw_addr = ADDR_W'(draw_y) * GW_A +
                ADDR_W'(draw_x);
  end

  // Free-running Galois LFSR, advances in every state.
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      lfsr <= SEED_I;
    end else if (lfsr[0]) begin
      lfsr <= (lfsr >> 1) ^ 16'hB400;
    end else begin
      lfsr <= lfsr >> 1;
    end
  end

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      state      <= IDLE;
      tries      <= '0;
      cand_x     <= '0;
      cand_y     <= '0;
      occ_rd_en  <= 1'b0;
      occ_addr   <= '0;
      food_x     <= '0;
      food_y     <= '0;
      food_valid <= 1'b0;
      busy       <= 1'b0;
      fail       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gen_req) begin
            state <= DRAW;
            busy  <= 1'b1;
            tries <= '0;
          end
        end
        DRAW: begin
          tries <= tries_n;
          if (!in_range) begin
            if (tries_n >= MT) begin
`ifdef FOOD_FALLBACK_SCAN_EN
              state     <= SCAN;
              occ_rd_en <= 1'b1;
              occ_addr  <= '0;
              cand_x    <= '0;
              cand_y    <= '0;
`else
              state <= FAIL;
              fail  <= 1'b1;
              busy  <= 1'b0;
`endif
            end
          end else begin
            state     <= READ;
            cand_x    <= draw_x;
            cand_y    <= draw_y;
            occ_rd_en <= 1'b1;
            occ_addr  <= draw_addr;
          end
        end
        READ: begin
          occ_rd_en <= 1'b0;
          state     <= CHECK;
        end
        CHECK: begin
          if (!occ_data) begin
            state      <= DONE;
            food_x     <= cand_x;
            food_y     <= cand_y;
            food_valid <= 1'b1;
            busy       <= 1'b0;
          end else if (tries >= MT) begin
`ifdef FOOD_FALLBACK_SCAN_EN
            state     <= SCAN;
            occ_rd_en <= 1'b1;
            occ_addr  <= '0;
            cand_x    <= '0;
            cand_y    <= '0;
`else
            state <= FAIL;
            fail  <= 1'b1;
            busy  <= 1'b0;
`endif
          end else begin
            state <= DRAW;
          end
        end
        DONE: begin
          food_valid <= 1'b0;
          state      <= IDLE;
        end
        FAIL: begin
          fail  <= 1'b0;
          state <= IDLE;
        end
`ifdef FOOD_FALLBACK_SCAN_EN
        SCAN: begin
          occ_rd_en <= 1'b0;
          state     <= SCAN_CHK;
        end
        // Walk cells in address order; x/y track occ_addr.
        SCAN_CHK: begin
          if (!occ_data) begin
            state      <= DONE;
            food_x     <= cand_x;
            food_y     <= cand_y;
            food_valid <= 1'b1;
            busy       <= 1'b0;
          end else if (occ_addr == LAST) begin
            state <= FAIL;
            fail  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state     <= SCAN;
            occ_rd_en <= 1'b1;
            occ_addr  <= occ_addr + 1'b1;
            if (cand_x == X_LAST) begin
              cand_x <= '0;
              cand_y <= cand_y + 1'b1;
            end else begin
              cand_x <= cand_x + 1'b1;
            end
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_food_gen.sv
// Directed bench for food_gen with an occupancy RAM model.
// Covers empty, nearly full and full grids, reset mid-search and extra requests.
module tb_food_gen;
  localparam int GW = 40;
  localparam int GH = 30;
  localparam int MT = 4;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic rstn;
  logic gen_req;
  logic occ_rd_en;
  logic [10:0] occ_addr;
  logic occ_data = 1'b0;
  logic [5:0] food_x;
  logic [4:0] food_y;
  logic food_valid;
  logic busy;
  logic fail;

  int checks = 0;
  int errors = 0;
  int mode = 0;
  int max_addr = 0;
  int last_x = 0;
  int last_y = 0;
  logic [15:0] m;

  always #5 clk = ~clk;

  food_gen #(
    .GRID_W(GW), .GRID_H(GH), .X_W(6), .Y_W(5),
    .ADDR_W(11), .MAX_TRIES(MT), .SEED(SEED)
  ) dut (
    .clk(clk), .RSTN(rstn), .gen_req(gen_req),
    .occ_rd_en(occ_rd_en), .occ_addr(occ_addr),
    .occ_data(occ_data), .food_x(food_x),
    .food_y(food_y), .food_valid(food_valid),
    .busy(busy), .fail(fail)
  );

  function automatic logic occ(input int md, input int a);
    return (md == 2) || (md == 1 && a != 285);
  endfunction

  function automatic logic [15:0] step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  always @(posedge clk) begin
    if (occ_rd_en) begin
      occ_data <= occ(mode, int'(occ_addr));
      if (int'(occ_addr) > max_addr)
        max_addr <= int'(occ_addr);
    end
  end

  always @(posedge clk or negedge rstn) begin
    if (!rstn) m <= SEED;
    else m <= step(m);
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d",
               nm, act, exp);
    end
  endtask

  // kind: 1 = food_valid, 2 = fail; cyc counted from the DRAW cycle
  typedef struct {
    int kind;
    int cyc;
    int x;
    int y;
  } pred_t;

  function automatic pred_t predict(input logic [15:0] l0,
                                    input int md);
    pred_t p;
    logic [15:0] l;
    int t, c, e, cx, cy;
    l = l0; t = 0; c = 0; e = -1;
    p.kind = 2; p.cyc = 0; p.x = -1; p.y = -1;
    while (e < 0) begin
      t++;
      cx = int'(l[5:0]);
      cy = int'(l[12:8]);
      if (cx >= GW || cy >= GH) begin
        if (t >= MT) e = c + 1;
        else begin c += 1; l = step(l); end
      end else begin
        if (!occ(md, cy * GW + cx)) begin
          p.kind = 1; p.cyc = c + 3;
          p.x = cx; p.y = cy;
          return p;
        end
        if (t >= MT) e = c + 3;
        else begin c += 3; l = step(step(step(l))); end
      end
    end
`ifdef FOOD_FALLBACK_SCAN_EN
    for (int k = 0; k < GW * GH; k++) begin
      if (!occ(md, k)) begin
        p.kind = 1; p.cyc = e + 2 * k + 2;
        p.x = k % GW; p.y = k / GW;
        return p;
      end
    end
    p.cyc = e + 2 * GW * GH;
`else
    p.cyc = e;
`endif
    return p;
  endfunction

  task automatic run_req(input int md, input bit second,
                         input bit at_done, input int ekind,
                         input int ex, input int ey);
    pred_t p;
    int k, strobes, kind, sc, sx, sy, busy_bad, both;
    k = 0; strobes = 0; kind = 0; sc = -1;
    sx = 0; sy = 0; busy_bad = 0; both = 0;
    mode = md;
    @(negedge clk);
    gen_req = 1'b1;
    @(posedge clk);
    #1;
    gen_req = 1'b0;
    chk("busy_rise", 32'(busy), 1);
    p = predict(m, md);
    while (k < 3000 && (sc < 0 || k < sc + 4)) begin
      @(posedge clk);
      #1;
      k++;
      gen_req = 1'b0;
      if (second && k == 1) gen_req = 1'b1;
      if (food_valid || fail) begin
        strobes++;
        if (food_valid && fail) both++;
        if (busy) busy_bad++;
        if (sc < 0) begin
          sc = k;
          kind = food_valid ? 1 : 2;
          sx = int'(food_x);
          sy = int'(food_y);
          if (at_done) gen_req = 1'b1;
        end
      end else if (sc < 0 && !busy) begin
        busy_bad++;
      end else if (sc >= 0 && busy) begin
        busy_bad++;
      end
    end
    gen_req = 1'b0;
    if (sc < 0)
      $display("FAIL timeout actual %0d required %0d", k, p.cyc);
    chk("strobe_cnt", 32'(strobes), 1);
    chk("exclusive", 32'(both), 0);
    chk("kind", 32'(kind), 32'(p.kind));
    chk("latency", 32'(sc), 32'(p.cyc));
    chk("busy_window", 32'(busy_bad), 0);
    if (ekind != 0) chk("kind_dir", 32'(kind), 32'(ekind));
    if (kind == 1) begin
      chk("x", 32'(sx), 32'(p.x));
      chk("y", 32'(sy), 32'(p.y));
      chk("in_range", 32'(sx < GW && sy < GH), 1);
      if (ex >= 0) begin
        chk("x_dir", 32'(sx), 32'(ex));
        chk("y_dir", 32'(sy), 32'(ey));
      end
      last_x = sx;
      last_y = sy;
    end else if (kind == 2) begin
      chk("x_hold", 32'(sx), 32'(last_x));
      chk("y_hold", 32'(sy), 32'(last_y));
    end
  endtask

  typedef struct {
    int md;
    bit second;
    bit at_done;
    int kind;
    int x;
    int y;
  } vec_t;

  vec_t tbl[5];
  int n;
  int seen;

  initial begin
`ifdef FOOD_FALLBACK_SCAN_EN
    tbl[0] = '{0, 1'b0, 1'b0, 1, -1, -1};
    tbl[1] = '{0, 1'b1, 1'b0, 1, -1, -1};
    tbl[2] = '{0, 1'b0, 1'b1, 1, -1, -1};
    tbl[3] = '{2, 1'b0, 1'b0, 2, -1, -1};
    tbl[4] = '{1, 1'b0, 1'b0, 1, 5, 7};
`else
    tbl[0] = '{0, 1'b0, 1'b0, 0, -1, -1};
    tbl[1] = '{0, 1'b1, 1'b0, 0, -1, -1};
    tbl[2] = '{0, 1'b0, 1'b1, 0, -1, -1};
    tbl[3] = '{2, 1'b0, 1'b0, 2, -1, -1};
    tbl[4] = '{1, 1'b0, 1'b0, 0, -1, -1};
`endif
    rstn = 1'b0;
    gen_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_food_x", 32'(food_x), 0);
    chk("rst_food_y", 32'(food_y), 0);
    chk("rst_valid", 32'(food_valid), 0);
    chk("rst_fail", 32'(fail), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rd_en", 32'(occ_rd_en), 0);
    chk("rst_addr", 32'(occ_addr), 0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (8) @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++)
      run_req(tbl[i].md, tbl[i].second, tbl[i].at_done,
              tbl[i].kind, tbl[i].x, tbl[i].y);

    // Reset while a read is outstanding.
    mode = 0;
    seen = 0;
    n = 0;
    while (!seen && n < 10) begin
      @(negedge clk);
      gen_req = 1'b1;
      @(posedge clk);
      #1;
      gen_req = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
        if (occ_rd_en) seen = 1;
        else begin @(posedge clk); #1; end
      end
      n++;
    end
    chk("rd_seen", 32'(seen), 1);
    #2;
    rstn = 1'b0;
    #1;
    chk("rstmid_rd_en", 32'(occ_rd_en), 0);
    chk("rstmid_busy", 32'(busy), 0);
    chk("rstmid_valid", 32'(food_valid), 0);
    chk("rstmid_fail", 32'(fail), 0);
    chk("rstmid_x", 32'(food_x), 0);
    last_x = 0;
    last_y = 0;
    seen = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (food_valid || fail || busy) seen++;
    end
    @(negedge clk);
    rstn = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (food_valid || fail || busy) seen++;
    end
    chk("rstmid_quiet", 32'(seen), 0);
    run_req(0, 1'b0, 1'b0, tbl[0].kind, -1, -1);

    chk("addr_range", 32'(max_addr < GW * GH), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/food_gen.md
# food_gen

Food placement unit for the greedy-snake game. It sits between the game state machine and the snake occupancy RAM. On a one-cycle generate request from the state machine, it draws pseudo-random grid coordinates and checks them against the RAM. Occupied or out-of-range draws are retried. It returns a free cell as `food_x`/`food_y` with a one-cycle valid strobe, which the movement and VGA stages consume.

## Interface
Parameters:
- `GRID_W`, 40: grid columns.
- `GRID_H`, 30: grid rows.
- `X_W`, 6: x coordinate width.
- `Y_W`, 5: y coordinate width.
- `ADDR_W`, 11: occupancy RAM address width.
- `MAX_TRIES`, 64: draw attempts before giving up, range 1..255.
- `SEED`, 16'hACE1: LFSR reset value. Zero is replaced by 16'hACE1.

Ports:
- `clk` in 1: system clock.
- `RSTN` in 1: asynchronous active-low reset.
- `gen_req` in 1: one-cycle generate request.
- `occ_rd_en` out 1: occupancy RAM read strobe.
- `occ_addr` out ADDR_W: RAM address, equal to y*GRID_W + x.
- `occ_data` in 1: cell occupied flag, valid one cycle after `occ_rd_en`.
- `food_x` out X_W: food column.
- `food_y` out Y_W: food row.
- `food_valid` out 1: one-cycle strobe when a new position is committed.
- `busy` out 1: high from acceptance of a request until the valid or fail strobe.
- `fail` out 1: one-cycle strobe when no free cell was found.

## Operation
- LFSR: 16-bit Galois, mask 16'hB400, shifts every cycle including IDLE. Candidate x = `lfsr[5:0]`, candidate y = `lfsr[12:8]`.
- FSM states: IDLE, DRAW, READ, CHECK, DONE, FAIL. All outputs are registered.
- IDLE:
  - `gen_req`=1 → DRAW, `busy`←1, try counter ←0.
  - `gen_req` while busy is ignored; no queueing.
- DRAW: sample the LFSR and increment the try counter.
  - Candidate x ≥ GRID_W or y ≥ GRID_H → remain in DRAW. If the counter has reached MAX_TRIES → FAIL.
  - Otherwise → READ, latching the candidate.
- READ: `occ_rd_en`=1 for exactly this cycle, with `occ_addr` = y*GRID_W+x. Next state is CHECK.
- CHECK: sample `occ_data`.
  - 0 → DONE.
  - 1 → DRAW, or FAIL if the counter has reached MAX_TRIES.
- DONE: `food_x`/`food_y` ← candidate, `food_valid`=1 for one cycle, `busy`←0, → IDLE.
- FAIL: `fail`=1 for one cycle, `busy`←0, `food_x`/`food_y` unchanged, → IDLE.
- `food_x`/`food_y` hold their value until the next DONE.
- Address arithmetic is computed at ADDR_W width, with no truncation for legal parameters (GRID_W*GRID_H ≤ 2^ADDR_W).

## Timing
- Reset values:
  - `food_x`=0, `food_y`=0.
  - `food_valid`=0, `fail`=0, `busy`=0.
  - `occ_rd_en`=0, `occ_addr`=0.
  - State = IDLE, LFSR = SEED.
- Minimum latency: `gen_req` sampled at edge N → `busy` high at N+1, `occ_rd_en` at N+2, `food_valid` at N+4.
- Each occupied retry costs 3 cycles (DRAW, READ, CHECK). Each range reject costs 1 cycle.
- `food_valid` and `fail` are mutually exclusive and never repeat without a new request.
- `RSTN` low mid-search returns to IDLE immediately (asynchronously). `occ_rd_en` drops and no strobe is emitted.
- `gen_req` asserted in the same cycle as DONE/FAIL is ignored. The requester re-issues it after `busy` falls.

## Configuration
- Macro: `FOOD_FALLBACK_SCAN_EN`.
- Defined: when MAX_TRIES is exhausted, the FSM enters SCAN instead of FAIL.
  - SCAN walks addresses 0,1,… via x/y counters (x wraps at GRID_W, y increments).
  - Each cell uses one READ and one CHECK cycle. The first free cell → DONE.
  - `fail` fires only if all GRID_W*GRID_H cells are occupied.
- Undefined: no SCAN state. Exhaustion → FAIL directly.

## Test plan
- Empty RAM (`occ_data`=0), reset, `gen_req` pulse at cycle 10 → `occ_rd_en` at 12, `food_valid` at 14 with an in-range position and `busy` high during cycles 11–13.
- RAM occupied except cell (x=5, y=7), addr 285, GRID 40×30, MAX_TRIES=255, macro defined → eventual `food_valid` with `food_x`=5, `food_y`=7. Every `occ_addr` is < 1200.
- Fully occupied RAM, macro undefined, MAX_TRIES=4 → `fail` strobe after ≤ 4 draws. `food_x`/`food_y` keep their previous values.
- Fully occupied RAM, macro defined → `fail` after all 1200 scanned reads, with no `food_valid`.
- `RSTN` pulsed low during READ → `occ_rd_en`=0 and `busy`=0 immediately, no strobes. A following `gen_req` completes normally.
- Second `gen_req` while `busy` → exactly one `food_valid` is produced.
